pu_seq_mac: RTL and testbench
=============================

# pu_seq_mac

Parametrised, time-multiplexed processing unit. Computes one neuron output as a saturated fixed-point dot product of N signed inputs and N signed weights, with a selectable identity/ReLU activation and a zero flag. It succeeds the fixed 4-input, 5-bit PU: a single shared multiplier is iterated over N channels, and valid/ready handshakes on both sides replace the external register-enable strobes. It sits between the layer controller (operand source) and the value/zero-detect logic (result sink).

## Interface

- `W`, default 5: data width, two's complement.
- `FRAC`, default 3: fractional bits. Default format is Q1.3, so 00010 = 0.25 and 11100 = -0.5.
- `N`, default 4: channel count, N ≥ 2.
- `clk` in, 1 bit: single clock. All state changes on the rising edge.
- `rst_n` in, 1 bit: reset, asynchronous, active-low.
- `in_valid` in, 1 bit: operand vector valid.
- `in_ready` out, 1 bit: unit can accept operands.
- `x_flat` in, N*W bits: inputs. Channel i occupies [i*W +: W].
- `w_flat` in, N*W bits: weights, same packing as `x_flat`.
- `act_mode` in, 1 bit: 0 = identity, 1 = ReLU. Sampled with the operands.
- `out_valid` out, 1 bit: result valid.
- `out_ready` in, 1 bit: sink accepts the result.
- `result` out, W bits: activated, saturated output.
- `zero_flag` out, 1 bit: `result` == 0. Qualified by `out_valid`.
- `sat_flag` out, 1 bit: saturation occurred. Qualified by `out_valid`.

## Operation

- FSM states: IDLE, MAC, NORM, OUT.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid`: capture `x_flat`, `w_flat` and `act_mode`; clear acc; set idx = 0; go to MAC.
- **MAC**
  - Each cycle: acc += x[idx] * w[idx], a signed 2W-bit product; idx++.
  - After idx = N-1 is accumulated, go to NORM.
  - Exactly N cycles.
- **NORM**, one cycle:
  - s = acc >>> FRAC (arithmetic shift, floor toward -inf).
  - If s > 2^(W-1)-1: clamp to 2^(W-1)-1 and set sat. If s < -2^(W-1): clamp to -2^(W-1) and set sat.
  - If mode = ReLU and the clamped value is negative, output 0. `sat_flag` is still reported.
  - Register `result`, `zero_flag` and `sat_flag`; go to OUT.
- **OUT**
  - `out_valid` = 1; outputs held stable.
  - On `out_ready`: go to IDLE.
- Accumulator width is 2W + clog2(N). Overflow of the accumulator is impossible by construction.
- `in_ready` = 0 in MAC, NORM and OUT. `in_valid` in those states is ignored and no operands are captured.
- Operand registers are unchanged outside IDLE acceptance.
- Every output is registered or decoded from state. There is no combinational in-to-out path.

## Timing

- Reset values:
  - state = IDLE, so `in_ready` = 1.
  - `out_valid` = 0, `result` = 0, `zero_flag` = 0, `sat_flag` = 0.
  - acc = 0, idx = 0.
- Latency: with acceptance on edge k, `out_valid` rises after edge k+N+1. Default N = 4 gives 5 cycles.
- Earliest next accept: the edge after the OUT handshake, because IDLE is re-entered first. Throughput is one result per N+3 cycles when `out_ready` is held at 1.
- `out_ready` held low: OUT persists indefinitely; `result` and the flags are held.
- `rst_n` asserted mid-operation, in any state: all outputs take their reset values immediately (asynchronous). The transaction is discarded, with no partial result. After release the unit is in IDLE.
- `out_ready` high while not in OUT: no effect.

## Structure

- Package `pu_pkg`:
  - State enum.
  - `ACT_IDENT` = 0, `ACT_RELU` = 1.
  - Accumulator-width function (2W + clog2(N)).
- Sub-module `pu_norm_sat`: combinational shift, floor, clamp and ReLU on the accumulator. Produces the result, zero and sat signals.
- Top level contains the FSM, idx counter, operand registers, multiplier and accumulator.

## Test plan

1. **Identity, mixed signs.** Defaults; x = {00010, 11100, 00100, 00110}; w all 00010; mode 0.
   - Expect `result` = 00010 (0.25), `zero_flag` = 0, `sat_flag` = 0.
   - `out_valid` rises exactly 5 cycles after accept.
2. **Floor rounding.** Same as scenario 1 with x1 = 00000.
   - Expect `result` = 00011 (0.375).
   - Then x all 00001, w all 00001: acc = 4/64, expect 00000 with `zero_flag` = 1.
   - Then x all 11111, w all 00001: expect 11111 (floor of -0.0625).
3. **Saturation.**
   - x = w = 01111 on all channels: expect 01111, `sat_flag` = 1.
   - x all 10000, w all 01111: expect 10000, `sat_flag` = 1.
4. **ReLU.** x all 11100, w all 00010 (sum -0.5).
   - Mode 0: expect 11100.
   - Mode 1: expect 00000, `zero_flag` = 1.
5. **Backpressure.** Hold `out_ready` = 0 for 3 cycles in OUT, and pulse `in_valid` with new operands meanwhile.
   - `result` stays stable and `in_ready` stays 0; the new operands are not captured.
   - After release, the next accept yields the correct fresh result.
6. **Reset mid-MAC.** Drop `rst_n` on the second MAC cycle.
   - `out_valid` = 0 and `result` = 0 immediately; `in_ready` = 1 after release.
   - Scenario 1 rerun produces 00010.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared types and helpers for the time-multiplexed processing unit.
package pu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_NORM = 2'd2,
    ST_OUT  = 2'd3
  } pu_state_e;

  localparam logic ACT_IDENT = 1'b0;
  localparam logic ACT_RELU  = 1'b1;

  // Accumulator width: full product width plus headroom for N terms.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/pu_norm_sat.sv
// Combinational normalisation: fractional shift (floor), clamp to W bits,
// optional ReLU, plus zero and saturation indications.
module pu_norm_sat
  import pu_pkg::*;
#(
  parameter int W     = 5,
  parameter int FRAC  = 3,
  parameter int ACC_W = 12
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    act_mode,
  output logic        [W-1:0]     result,
  output logic                    zero,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);

  // Returns {sat, value}: value clamped into the signed W-bit range.
  function automatic logic [W:0] clamp_w(input logic signed [ACC_W-1:0] s);
    if (s > S_MAX) begin
      clamp_w = {1'b1, S_MAX[W-1:0]};
    end else if (s < S_MIN) begin
      clamp_w = {1'b1, S_MIN[W-1:0]};
    end else begin
      clamp_w = {1'b0, s[W-1:0]};
    end
  endfunction

  logic signed [ACC_W-1:0] shifted;
  logic        [W:0]       clamped;

  // Arithmetic shift floors toward -inf; ReLU only masks the value, not sat.
  always_comb begin
    shifted = acc >>> FRAC;
    clamped = clamp_w(shifted);
    sat     = clamped[W];
    result  = clamped[W-1:0];
    if (act_mode == ACT_RELU && clamped[W-1]) begin
      result = '0;
    end
    zero = (result == '0);
  end

endmodule

// File: rtl/pu_seq_mac.sv
// Sequential MAC processing unit: one shared multiplier iterated over N
// channels, valid/ready on operand and result sides.
module pu_seq_mac
  import pu_pkg::*;
#(
  parameter int W    = 5,
  parameter int FRAC = 3,
  parameter int N    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] x_flat,
  input  logic [N*W-1:0] w_flat,
  input  logic           act_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           zero_flag,
  output logic           sat_flag
);

  localparam int ACC_W = acc_width(W, N);
  localparam int IDX_W = $clog2(N);
  localparam int EXT_W = ACC_W - 2 * W;

  pu_state_e               state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N*W-1:0]          x_q, x_d;
  logic [N*W-1:0]          w_q, w_d;
  logic                    mode_q, mode_d;
  logic [W-1:0]            result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    sat_q, sat_d;

  logic signed [W-1:0]     x_sel, w_sel;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [W-1:0]            norm_result;
  logic                    norm_zero, norm_sat;

  // Shared multiplier on the channel selected by idx.
  always_comb begin
    x_sel    = x_q[idx_q*W +: W];
    w_sel    = w_q[idx_q*W +: W];
    prod     = x_sel * w_sel;
    prod_ext = {{EXT_W{prod[2*W-1]}}, prod};
  end

  pu_norm_sat #(
    .W    (W),
    .FRAC (FRAC),
    .ACC_W(ACC_W)
  ) u_norm (
    .acc     (acc_q),
    .act_mode(mode_q),
    .result  (norm_result),
    .zero    (norm_zero),
    .sat     (norm_sat)
  );

  // Next-state and datapath update for the IDLE/MAC/NORM/OUT sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    x_d      = x_q;
    w_d      = w_q;
    mode_d   = mode_q;
    result_d = result_q;
    zero_d   = zero_q;
    sat_d    = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_flat;
          w_d     = w_flat;
          mode_d  = act_mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_ext;
        if (idx_q == IDX_W'(N - 1)) begin
          idx_d   = '0;
          state_d = ST_NORM;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_NORM: begin
        result_d = norm_result;
        zero_d   = norm_zero;
        sat_d    = norm_sat;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, accumulator and result registers; async reset discards any
  // in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sat_q    <= sat_d;
    end
  end

  // Operand registers only change on IDLE acceptance; they need no reset.
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    w_q    <= w_d;
    mode_q <= mode_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_pu_seq_mac.sv
// Randomised and directed bench for pu_seq_mac with a behavioural model.
module tb_pu_seq_mac;

  localparam int W    = 5;
  localparam int FRAC = 3;
  localparam int N    = 4;
  localparam int LAT  = N + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] x_flat = '0;
  logic [N*W-1:0] w_flat = '0;
  logic           act_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   result;
  logic           zero_flag;
  logic           sat_flag;

  int total = 0;
  int bad   = 0;

  pu_seq_mac #(.W(W), .FRAC(FRAC), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_flat   (x_flat),
    .w_flat   (w_flat),
    .act_mode (act_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero_flag(zero_flag),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  // Pack four channel values, channel 0 in the low bits.
  function automatic logic [N*W-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [W-1:0] a, b, c, d;
    a = W'(c0); b = W'(c1); c = W'(c2); d = W'(c3);
    return {d, c, b, a};
  endfunction

  // Reference: real-valued dot product, floored to the output grid,
  // clamped, then optional ReLU.
  function automatic void model(input logic [N*W-1:0] xv, input logic [N*W-1:0] wv,
                                input logic mode, output logic [W-1:0] r,
                                output logic z, output logic s);
    int sum, q, lo, hi, xi, wi;
    logic [W-1:0] xs, ws;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      xs = xv[i*W +: W];
      ws = wv[i*W +: W];
      xi = int'($signed(xs));
      wi = int'($signed(ws));
      sum += xi * wi;
    end
    q = sum / (1 << FRAC);
    if ((sum % (1 << FRAC)) != 0 && sum < 0) q = q - 1;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    s = 1'b0;
    if (q > hi) begin q = hi; s = 1'b1; end
    if (q < lo) begin q = lo; s = 1'b1; end
    if (mode && q < 0) q = 0;
    r = W'(q);
    z = (q == 0);
  endfunction

  // Drive one transaction and report observed outputs and latency.
  task automatic run_txn(input logic [N*W-1:0] xv, input logic [N*W-1:0] wv,
                         input logic mode, input int hold,
                         output logic [W-1:0] r, output logic z, output logic s,
                         output int lat, output bit timeout);
    timeout  = 1'b0;
    x_flat   = xv;
    w_flat   = wv;
    act_mode = mode;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
    r = result; z = zero_flag; s = sat_flag;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%b want=00000", result); end
    total++; if (zero_flag !== 1'b0 || sat_flag !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", zero_flag, sat_flag); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [N*W-1:0] xs [8];
    logic [N*W-1:0] ws [8];
    logic           ms [8];
    logic [W-1:0]   er [8];
    logic [1:0]     ef [8];
    logic [W-1:0] r, mr;
    logic z, s, mz, ms_;
    int lat;
    bit to;
    xs[0] = pk(2, -4, 4, 6);     ws[0] = pk(2, 2, 2, 2);       ms[0] = 0; er[0] = 5'b00010; ef[0] = 2'b00;
    xs[1] = pk(2, 0, 4, 6);      ws[1] = pk(2, 2, 2, 2);       ms[1] = 0; er[1] = 5'b00011; ef[1] = 2'b00;
    xs[2] = pk(1, 1, 1, 1);      ws[2] = pk(1, 1, 1, 1);       ms[2] = 0; er[2] = 5'b00000; ef[2] = 2'b10;
    xs[3] = pk(-1, -1, -1, -1);  ws[3] = pk(1, 1, 1, 1);       ms[3] = 0; er[3] = 5'b11111; ef[3] = 2'b00;
    xs[4] = pk(15, 15, 15, 15);  ws[4] = pk(15, 15, 15, 15);   ms[4] = 0; er[4] = 5'b01111; ef[4] = 2'b01;
    xs[5] = pk(-16, -16, -16, -16); ws[5] = pk(15, 15, 15, 15); ms[5] = 0; er[5] = 5'b10000; ef[5] = 2'b01;
    xs[6] = pk(-4, -4, -4, -4);  ws[6] = pk(2, 2, 2, 2);       ms[6] = 0; er[6] = 5'b11100; ef[6] = 2'b00;
    xs[7] = pk(-4, -4, -4, -4);  ws[7] = pk(2, 2, 2, 2);       ms[7] = 1; er[7] = 5'b00000; ef[7] = 2'b10;
    for (int k = 0; k < 8; k++) begin
      model(xs[k], ws[k], ms[k], mr, mz, ms_);
      run_txn(xs[k], ws[k], ms[k], 0, r, z, s, lat, to);
      total++; if (to) begin bad++; $display("FAIL dir%0d_timeout got=none want=out_valid", k); end
      total++; if (r !== er[k]) begin bad++; $display("FAIL dir%0d_result got=%b want=%b", k, r, er[k]); end
      total++; if ({z, s} !== ef[k]) begin bad++; $display("FAIL dir%0d_flags got=%b%b want=%b", k, z, s, ef[k]); end
      total++; if (r !== mr || z !== mz || s !== ms_) begin bad++; $display("FAIL dir%0d_model got=%b want=%b", k, r, mr); end
      total++; if (lat != LAT) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, LAT); end
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] xa, wa, xb, wb;
    logic [W-1:0] mr, held;
    logic mz, ms_, z, s;
    int lat;
    bit to;
    logic [W-1:0] r;
    xa = pk(6, 6, 2, 0); wa = pk(4, 2, 2, 2);
    model(xa, wa, 1'b0, mr, mz, ms_);
    x_flat = xa; w_flat = wa; act_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    total++; if (!out_valid) begin bad++; $display("FAIL bp_timeout got=none want=out_valid"); end
    held = result;
    total++; if (held !== mr) begin bad++; $display("FAIL bp_result got=%b want=%b", held, mr); end
    for (int c = 0; c < 3; c++) begin
      x_flat = pk(15, 15, 15, 15); w_flat = pk(15, 15, 15, 15); in_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (result !== held || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%b/%b want=%b/1", c, result, out_valid, held); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b want=0", c, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b want=1/0", in_ready, out_valid); end
    xb = pk(-3, 5, 7, -2); wb = pk(3, -6, 2, 5);
    model(xb, wb, 1'b0, mr, mz, ms_);
    run_txn(xb, wb, 1'b0, 0, r, z, s, lat, to);
    total++; if (to || r !== mr || z !== mz || s !== ms_) begin bad++; $display("FAIL bp_fresh got=%b%b%b want=%b%b%b", r, z, s, mr, mz, ms_); end
  endtask

  task automatic test_reset_mid_mac();
    logic [W-1:0] r;
    logic z, s;
    int lat;
    bit to;
    run_txn(pk(7, 7, 7, 7), pk(5, 5, 5, 5), 1'b0, 0, r, z, s, lat, to);
    total++; if (r === '0) begin bad++; $display("FAIL rst_pre_result got=%b want=nonzero", r); end
    x_flat = pk(2, -4, 4, 6); w_flat = pk(2, 2, 2, 2); act_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || result !== '0) begin bad++; $display("FAIL rst_mid_outputs got=%b/%b want=0/00000", out_valid, result); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b/%b want=1/0", in_ready, out_valid); end
    run_txn(pk(2, -4, 4, 6), pk(2, 2, 2, 2), 1'b0, 0, r, z, s, lat, to);
    total++; if (to || r !== 5'b00010 || lat != LAT) begin bad++; $display("FAIL rst_rerun got=%b lat=%0d want=00010 lat=%0d", r, lat, LAT); end
  endtask

  task automatic test_random();
    logic [N*W-1:0] xv, wv;
    logic mode, mz, ms_, z, s;
    logic [W-1:0] mr, r;
    int lat;
    bit to;
    for (int k = 0; k < 40; k++) begin
      xv   = (N*W)'($urandom);
      wv   = (N*W)'($urandom);
      mode = 1'($urandom_range(0, 1));
      model(xv, wv, mode, mr, mz, ms_);
      run_txn(xv, wv, mode, int'($urandom_range(0, 2)), r, z, s, lat, to);
      total++; if (to || r !== mr || z !== mz || s !== ms_) begin bad++; $display("FAIL rnd%0d got=%b z%b s%b want=%b z%b s%b", k, r, z, s, mr, mz, ms_); end
      total++; if (lat != LAT) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, lat, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
